spi_wb_sequencer: RTL

- Wishbone master that drives the simple_spi_top register file on behalf of a byte-stream client.
- Sits directly upstream of simple_spi_top on its 8-bit Wishbone slave port, as an alternative to the I2C-to-Wishbone bridge.
- Per command it enables the core, asserts chip-select, writes each TX byte to SPDR, polls SPSR until the byte has been received, reads SPDR and emits the RX byte.
- Sequences an N-byte full-duplex SPI transaction and deasserts chip-select at the end.

---
 rtl/spi_seq_pkg.sv | 41 ++++
 rtl/wb_single_master.sv | 61 ++++++
 rtl/spi_wb_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI-over-Wishbone sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_TXW,
        ST_WDAT,
        ST_POLL,
        ST_RDAT,
        ST_RXO,
        ST_FIN
    } state_t;

    // simple_spi_top register map
    localparam logic [7:0] REG_SPCR = 8'h00;
    localparam logic [7:0] REG_SPSR = 8'h01;
    localparam logic [7:0] REG_SPDR = 8'h02;

    // SPCR / SPSR bit positions
    localparam int unsigned SPCR_SPE     = 6;
    localparam int unsigned SPCR_MSTR    = 4;
    localparam int unsigned SPCR_CPOL    = 3;
    localparam int unsigned SPCR_CPHA    = 2;
    localparam int unsigned SPSR_RFEMPTY = 0;

    // SPCR image: enabled master with the given {CPOL,CPHA,SPR}, or all-zero when disabled
    function automatic logic [7:0] spcr_value(input logic en, input logic [3:0] mode);
        logic [7:0] v;
        v = '0;
        if (en) begin
            v[SPCR_SPE]  = 1'b1;
            v[SPCR_MSTR] = 1'b1;
            v[SPCR_CPOL] = mode[3];
            v[SPCR_CPHA] = mode[2];
            v[1:0]       = mode[1:0];
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single-access Wishbone master: one request in, one done pulse (with read data) out.
module wb_single_master (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [7:0] i_adr,
    input  logic [7:0] i_wdat,
    output logic       o_done,
    output logic [7:0] o_rdat,
    output logic       o_wb_cyc,
    output logic       o_wb_stb,
    output logic       o_wb_we,
    output logic [7:0] o_wb_adr,
    output logic [7:0] o_wb_dat,
    input  logic [7:0] i_wb_dat,
    input  logic       i_wb_ack
);

    logic       r_cyc;
    logic       r_we;
    logic [7:0] r_adr;
    logic [7:0] r_dat;
    logic       r_done;
    logic [7:0] r_rdat;

    // Launch a cycle on request, hold it until ack; the done cycle doubles as the mandatory idle gap
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cyc  <= 1'b0;
            r_we   <= 1'b0;
            r_adr  <= '0;
            r_dat  <= '0;
            r_done <= 1'b0;
            r_rdat <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_cyc) begin
                if (i_wb_ack) begin
                    r_cyc  <= 1'b0;
                    r_done <= 1'b1;
                    r_rdat <= i_wb_dat;
                end
            end else if (i_req && !r_done) begin
                r_cyc <= 1'b1;
                r_we  <= i_we;
                r_adr <= i_adr;
                r_dat <= i_wdat;
            end
        end
    end

    assign o_done   = r_done;
    assign o_rdat   = r_rdat;
    assign o_wb_cyc = r_cyc;
    assign o_wb_stb = r_cyc;
    assign o_wb_we  = r_we;
    assign o_wb_adr = r_adr;
    assign o_wb_dat = r_dat;

endmodule

// File: rtl/spi_wb_sequencer.sv
// Byte-stream to simple_spi_top sequencer: runs an N-byte full-duplex SPI transfer over Wishbone.
module spi_wb_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned POLL_MAX = 1023,
    parameter logic [7:0]  ADR_SPCR = REG_SPCR,
    parameter logic [7:0]  ADR_SPSR = REG_SPSR,
    parameter logic [7:0]  ADR_SPDR = REG_SPDR
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       cfg_mode_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic [7:0]       tx_data_i,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic [7:0]       rx_data_o,
    output logic             ss_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [7:0]       wb_adr_o,
    output logic [7:0]       wb_dat_o,
    input  logic [7:0]       wb_dat_i,
    input  logic             wb_ack_i
);

    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    state_t           r_state, w_next;
    logic [LEN_W-1:0] r_len, r_cnt;
    logic [3:0]       r_mode;
    logic [PW-1:0]    r_poll;
    logic [7:0]       r_tx, r_rx;
    logic             r_ss_n, r_err, r_done;

    logic             w_req, w_we, w_xfer_done;
    logic [7:0]       w_adr, w_wdat, w_rdat;
    logic             w_rfempty, w_poll_hit, w_last;

    assign w_rfempty  = w_rdat[SPSR_RFEMPTY];
    assign w_poll_hit = (r_poll == PW'(POLL_MAX));
    assign w_last     = (r_cnt == r_len);

    wb_single_master u_wbm (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_req    (w_req),
        .i_we     (w_we),
        .i_adr    (w_adr),
        .i_wdat   (w_wdat),
        .o_done   (w_xfer_done),
        .o_rdat   (w_rdat),
        .o_wb_cyc (wb_cyc_o),
        .o_wb_stb (wb_stb_o),
        .o_wb_we  (wb_we_o),
        .o_wb_adr (wb_adr_o),
        .o_wb_dat (wb_dat_o),
        .i_wb_dat (wb_dat_i),
        .i_wb_ack (wb_ack_i)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and Wishbone request decode
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_we   = 1'b0;
        w_adr  = ADR_SPCR;
        w_wdat = '0;
        case (r_state)
            ST_IDLE: if (cmd_valid_i) w_next = ST_CFG;
            ST_CFG: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_adr  = ADR_SPCR;
                w_wdat = spcr_value(1'b1, r_mode);
                if (w_xfer_done) w_next = ST_TXW;
            end
            ST_TXW: if (tx_valid_i) w_next = ST_WDAT;
            ST_WDAT: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_adr  = ADR_SPDR;
                w_wdat = r_tx;
                if (w_xfer_done) w_next = ST_POLL;
            end
            ST_POLL: begin
                w_req = 1'b1;
                w_adr = ADR_SPSR;
                if (w_xfer_done) begin
                    if (!w_rfempty)     w_next = ST_RDAT;
                    else if (w_poll_hit) w_next = ST_FIN;
                end
            end
            ST_RDAT: begin
                w_req = 1'b1;
                w_adr = ADR_SPDR;
                if (w_xfer_done) w_next = ST_RXO;
            end
            ST_RXO: if (rx_ready_i) w_next = w_last ? ST_FIN : ST_TXW;
            ST_FIN: begin
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_adr  = ADR_SPCR;
                w_wdat = spcr_value(1'b0, r_mode);
                if (w_xfer_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command, byte/poll counters, data latches and status flags
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_mode <= '0;
            r_poll <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_ss_n <= 1'b1;
            r_err  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (cmd_valid_i) begin
                    r_len  <= cmd_len_i;
                    r_mode <= cfg_mode_i;
                    r_err  <= 1'b0;
                    r_cnt  <= '0;
                end
                ST_CFG:  if (w_xfer_done) r_ss_n <= 1'b0;
                ST_TXW:  if (tx_valid_i) r_tx <= tx_data_i;
                ST_WDAT: if (w_xfer_done) r_poll <= '0;
                ST_POLL: if (w_xfer_done && w_rfempty) begin
                    if (w_poll_hit) r_err  <= 1'b1;
                    else            r_poll <= r_poll + PW'(1);
                end
                ST_RDAT: if (w_xfer_done) r_rx <= w_rdat;
                ST_RXO:  if (rx_ready_i && !w_last) r_cnt <= r_cnt + LEN_W'(1);
                ST_FIN:  if (w_xfer_done) begin
                    r_ss_n <= 1'b1;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign tx_ready_o  = (r_state == ST_TXW) && tx_valid_i;
    assign rx_valid_o  = (r_state == ST_RXO);
    assign rx_data_o   = r_rx;
    assign ss_n_o      = r_ss_n;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
